// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The MMIO decode helper lives here so that other blocks decode the window the same way.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CYCLE_OFS = 32'd0;
  localparam logic [31:0] DBG_OFS   = 32'd4;

  function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: the write is synchronous and the read is asynchronous.
// There is a single index, shared by the read path and the write path.
module dmem_array #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wd;
    end
  end

  assign rd = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the core's M stage. It wraps the word array with a configurable
// latency and a stall handshake, and it adds a small MMIO window (cycle counter, debug register).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic [31:0] dbg_out
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   dbg_q, dbg_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          accept;
  logic          fsm_done;
  logic          acc_fire;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          req_seen;
  logic          acc_misal;
  logic          acc_mmio;
  logic [31:0]   acc_ofs;
  logic [31:0]   arr_rd;
  logic [31:0]   rd_val;
  logic          arr_we;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (LATENCY == 0) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid) state_d = (LATENCY > 1) ? BUSY : DONE;
        BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs. DONE never accepts, so a request still held high in DONE is not taken twice.
  always_comb begin
    stall    = 1'b0;
    accept   = 1'b0;
    fsm_done = 1'b0;
    if (LATENCY != 0) begin
      case (state_q)
        IDLE: begin
          stall  = req_valid;
          accept = req_valid;
        end
        BUSY:    stall = 1'b1;
        DONE:    fsm_done = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Choose the active access: the live request when LATENCY is zero, otherwise the latched copy.
  generate
    if (LATENCY == 0) begin : g_zero_lat
      assign acc_fire  = req_valid;
      assign acc_write = req_write;
      assign acc_addr  = req_addr;
      assign acc_wdata = req_wdata;
      assign req_seen  = req_valid;
    end else begin : g_multi_lat
      assign acc_fire  = fsm_done;
      assign acc_write = wr_q;
      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
      assign req_seen  = accept;
    end
  endgenerate

  assign acc_misal = |acc_addr[1:0];
  assign acc_mmio  = is_mmio(acc_addr, MMIO_BASE);
  assign acc_ofs   = acc_addr - MMIO_BASE;

  // The latched request copy and the latency down-counter
  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      cnt_d   = CNT_LOAD;
      wr_d    = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // A misaligned access is checked before the address decode, so it reads 0 whether it targets MMIO or the array.
  always_comb begin
    rd_val = 32'd0;
    if (!acc_misal) begin
      if (acc_mmio) begin
        if (acc_ofs == CYCLE_OFS) begin
          rd_val = cyc_q;
        end else if (acc_ofs == DBG_OFS) begin
          rd_val = dbg_q;
        end
      end else begin
        rd_val = arr_rd;
      end
    end
  end

  always_comb begin
    cyc_d   = cyc_q + 32'd1;
    err_d   = err_q | (req_seen & (|req_addr[1:0]));
    dbg_d   = dbg_q;
    rdata_d = rdata_q;
    if (acc_fire) begin
      rdata_d = rd_val;
      if (acc_write && !acc_misal && acc_mmio && (acc_ofs == DBG_OFS)) begin
        dbg_d = acc_wdata;
      end
    end
  end

  assign arr_we = acc_fire & acc_write & ~acc_misal & ~acc_mmio & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
      dbg_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
      dbg_q   <= dbg_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk(clk),
    .we (arr_we),
    .idx(acc_addr[AW+1:2]),
    .wd (acc_wdata),
    .rd (arr_rd)
  );

  assign rdata        = acc_fire ? rd_val : rdata_q;
  assign misalign_err = err_q;
  assign dbg_out      = dbg_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the mips core's data port (M stage). It is the target side of the core's mem_writeM / alu_outM / write_data / read_data interface.
- Replaces the zero-latency dmem with a word-addressed SRAM model that has configurable access latency. Stalls the core with a stall handshake while an access is outstanding.
- Also decodes a small MMIO window: a free-running cycle counter (read-only) and a debug output register (read/write).

Parameters:
- DEPTH, 64, number of 32-bit words in the backing array (power of 2).
- LATENCY, 2, cycles from request acceptance to completion; 0 means single-cycle, no stall.
- MMIO_BASE, 32'hFFFF_0000, first MMIO address; addresses >= MMIO_BASE are MMIO.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core has a load or store in M stage.
- req_write  in  1  1 = store, 0 = load; valid with req_valid.
- req_addr  in  32  byte address (alu_outM).
- req_wdata  in  32  store data (write_data).
- rdata  out  32  load data; valid in the completion cycle.
- stall  out  1  core must hold M stage and everything upstream.
- misalign_err  out  1  sticky flag: an access with req_addr[1:0] != 0 was seen.
- dbg_out  out  32  MMIO debug register contents.

Behaviour:
- Reset: state IDLE, stall 0, rdata 0, misalign_err 0, dbg_out 0, cycle counter 0, latency counter 0. Array contents are not reset.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, req_valid=1, LATENCY>0:
  - latch write, addr and wdata; load down-counter with LATENCY-1.
  - go to BUSY if LATENCY>1, else go to DONE.
  - stall=1 in this cycle (combinational from req_valid in IDLE).
- BUSY:
  - stall=1; decrement the counter.
  - when counter==0, go to DONE next cycle.
  - req inputs are ignored; the latched copy is authoritative.
- DONE:
  - stall=0; rdata driven from the latched address.
  - a store commits at the end of this cycle.
  - next state is IDLE. A req_valid seen in DONE is the same request and is not re-accepted.
- Total stall cycles per access = LATENCY. A load's data appears exactly LATENCY cycles after the first req_valid cycle.
- LATENCY=0: FSM stays in IDLE and stall is tied to 0.
  - rdata is combinational from req_addr.
  - a store commits at the edge at the end of the request cycle.
- Back-to-back: a request in the cycle immediately after DONE is accepted from IDLE normally. Consecutive accesses therefore cost LATENCY+1 cycles each.
- Array index = addr[$clog2(DEPTH)+1:2]. Upper bits are ignored below MMIO_BASE, so addresses alias (wrap-around).
- Misaligned access (addr[1:0]!=0):
  - still goes through full latency.
  - load returns 32'h0; store is dropped.
  - misalign_err is set, and only reset clears it.
- MMIO map:
  - MMIO_BASE+0: cycle counter, read-only. It increments every cycle after reset and wraps at 2^32. Stores to it are dropped.
  - MMIO_BASE+4: dbg_out, read/write. A store updates dbg_out at DONE (or at the request edge when LATENCY=0).
  - Other MMIO offsets: read 0, store dropped.
- rdata holds its last value outside DONE; it is only guaranteed in DONE (or same cycle when LATENCY=0).
- Reset mid-operation: FSM returns to IDLE, no store commits, and stall drops in the cycle after reset is sampled.

Decomposition:
- dmem_pkg holds:
  - the state_t enum {IDLE, BUSY, DONE};
  - MMIO offset constants CYCLE_OFS=0 and DBG_OFS=4;
  - the function is_mmio(addr, base).
- One sub-module, dmem_array: synchronous-write / async-read word array, parameterised by DEPTH, with ports clk, we, idx, wd, rd.
- FSM, MMIO decode and counters live in dmem_responder.

Test Plan:
- Basic store then load (LATENCY=2):
  - stimulus: store 0xDEADBEEF to addr 0x10, then load 0x10.
  - store: stall high 2 cycles, then DONE.
  - load: stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- Reset mid-access:
  - stimulus: store 0x12345678 to 0x20; assert reset in the BUSY cycle; afterwards load 0x20.
  - required: stall=0 after reset, and the load does not return 0x12345678 (the store was not committed).
- Misalign:
  - stimulus: load 0x13; store 0xAAAA5555 to 0x22.
  - required: load rdata=0, misalign_err=1 and stays 1, word 0x20 unchanged.
- Aliasing (DEPTH=64):
  - stimulus: store 0x11 to 0x100, load 0x000.
  - required: rdata=0x11 (index wraps at 256 bytes).
- MMIO:
  - stimulus: store 0xCAFE to MMIO_BASE+4; load MMIO_BASE+0 twice, 10 cycles apart.
  - required: dbg_out=0xCAFE; the second counter value exceeds the first by exactly 10 plus the handshake cycles between the two DONE cycles.
- LATENCY=0 build:
  - stimulus: store then load every cycle.
  - required: stall never asserted, rdata matches same cycle, and it behaves like the original dmem.
